data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-requester arbiter and sequencer for the 8-word × 16-bit data memory. Port 0 (core load/store) and port 1 (debug/DMA) each present a valid/ready request. The block grants one request at a time with round-robin fairness and drives the memory's shared address, write-data, write-enable and read-enable lines from registers. It then returns read data or a write acknowledgement, plus an out-of-range error flag, on the granted port's response channel. It sits between the requesters and the data memory; the memory remains the only storage.

## Interface
- ADDR_W, 16, request/memory address width
- DATA_W, 16, data width
- DEPTH_LOG2, 3, memory index bits; addresses with any bit in [ADDR_W-1:DEPTH_LOG2] set are out of range
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- reqN_valid  in  1  request present on port N (N = 0, 1)
- reqN_ready  out  1  request accepted this cycle when valid & ready
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  word address
- reqN_wdata  in  DATA_W  write data
- rspN_valid  out  1  response present on port N
- rspN_ready  in  1  requester takes response
- rspN_rdata  out  DATA_W  read data; 0 for writes and errors
- rspN_err  out  1  address out of range
- mem_access_addr  out  ADDR_W  to memory
- mem_write_data  out  DATA_W  to memory
- mem_write_en  out  1  to memory
- mem_read  out  1  to memory
- mem_read_data  in  DATA_W  from memory; combinational in the address, 0 when mem_read = 0

## Operation
- FSM states:
  - IDLE: accepts one request.
  - ACCESS: drives the memory for exactly one cycle.
  - RESP: holds the response.
- IDLE → ACCESS on a handshake. ACCESS → RESP always. RESP → IDLE on rspG_ready, where G is the granted port.
- Grant in IDLE (combinational):
  - Only one valid: that port wins.
  - Both valid: the port not served last wins.
  - The last-served pointer resets to 1, so port 0 wins the first tie.
- reqN_ready = (state == IDLE) && grant == N. The other port's ready is 0, and ready is 0 outside IDLE.
- On acceptance, register grant, we, addr, wdata, and err = |addr[ADDR_W-1:DEPTH_LOG2]. Update the last-served pointer.
- In ACCESS:
  - mem_access_addr = registered addr.
  - mem_write_data = registered wdata.
  - mem_write_en = we & ~err.
  - mem_read = ~we & ~err.
- All mem_* outputs are 0 in IDLE and RESP, so the memory is never written or read outside ACCESS.
- At the edge leaving ACCESS, latch rsp_rdata = mem_read_data for an in-range read, else 0. Latch rsp_err.
- In RESP, only rspG_valid = 1. rdata and err are stable until the handshake. The non-granted port's rsp outputs are 0.
- Out-of-range requests complete normally with err = 1. No memory side effect.
- Reset values: state IDLE; all ready, rsp_valid, rsp_err, rsp_rdata, and mem_* outputs 0.

## Timing
- Accept at cycle N. ACCESS in cycle N+1; the write commits at the edge ending N+1. rsp_valid from cycle N+2.
- If rsp_ready is high in N+2, the next accept is earliest N+3. Throughput is 1 request per 3 cycles under zero backpressure.
- Backpressure: RESP holds indefinitely. Requests on both ports stall; their valid and payload must stay stable until ready.
- Simultaneous valid on both ports: exactly one handshake per IDLE cycle. Ports alternate under continuous contention.
- A request arriving while RESP completes is not accepted until the following IDLE cycle. There is no IDLE bypass.
- Reset mid-operation: rst_n low clears state asynchronously and drops the in-flight transaction.
  - mem_write_en falls before the next edge, so a write in ACCESS during reset is not performed.
  - No response is issued after reset.

## Structure
- Shared package data_mem_pkg:
  - FSM state encoding (IDLE/ACCESS/RESP).
  - ADDR_W, DATA_W, DEPTH_LOG2 defaults.
  - Port index constants PORT_CORE = 0, PORT_DMA = 1.
- One natural sub-module: rr_arbiter2. It takes two valids, the last-served pointer and an enable, and produces a one-hot grant plus the pointer update.
- Everything else is in data_mem_arbiter.

## Test plan
- Port 0 write addr 3 data 16'hA5A5, then port 0 read addr 3 → write commits at the ACCESS edge; read response rdata = 16'hA5A5, err = 0; rsp_valid 2 cycles after each accept.
- Both ports valid continuously with reads of addr 1 and 2 → grants alternate 0,1,0,1; each rsp on the correct port only; first tie after reset goes to port 0.
- Port 1 write addr 16'h0008 data 16'hFFFF → rsp1_err = 1, rdata = 0, mem_write_en never 1; a subsequent read of addr 0 returns its prior value.
- Hold rsp0_ready low for 5 cycles in RESP with port 1 valid → rdata/err stable, req1_ready = 0 throughout; port 1 accepted in the cycle after the handshake.
- Assert rst_n low during ACCESS of a write addr 5 data 16'h1234 → all outputs 0 immediately, no response issued, memory addr 5 unchanged.
- Back-to-back port 0 reads with rsp0_ready tied high → accepts at cycles N, N+3, N+6; mem_read high only in N+1, N+4, N+7.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter: default widths, port indices
// and the sequencer state encoding.
package data_mem_pkg;

   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_DATA_W     = 16;
   localparam int DEF_DEPTH_LOG2 = 3;

   localparam int PORT_CORE = 0;
   localparam int PORT_DMA  = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// Two-way round-robin arbiter: one-hot grant while enabled, plus the
// next value of the last-served pointer.
module rr_arbiter2
   import data_mem_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       last_nxt
);

   logic winner;

   always_comb begin
      winner   = 1'b0;
      gnt      = 2'b00;
      last_nxt = last;
      // On a tie the port that was not served last takes the slot.
      if (valid == 2'b11) begin
         winner = ~last;
      end else begin
         winner = valid[PORT_DMA];
      end
      if (en && (|valid)) begin
         gnt[winner] = 1'b1;
         last_nxt    = winner;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and sequencer between the core and DMA ports and the
// 8-word data memory: IDLE accepts, ACCESS drives the memory, RESP returns.
module data_mem_arbiter
   import data_mem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp0_err,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp1_err,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);

   function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] a);
      return |a[ADDR_W-1:DEPTH_LOG2];
   endfunction

   state_e            state;
   logic              last_q;
   logic              gnt_port_q;
   logic              rsp_vld_q;
   logic              mem_we_q;
   logic              mem_rd_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;

   logic [1:0]        gnt;
   logic              last_nxt;
   logic              accept;
   logic              sel;
   logic              sel_we;
   logic              sel_err;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              rsp_hs;

   rr_arbiter2 u_arb (
      .valid    ({req1_valid, req0_valid}),
      .last     (last_q),
      .en       (state == ST_IDLE),
      .gnt      (gnt),
      .last_nxt (last_nxt)
   );

   assign accept     = |gnt;
   assign sel        = gnt[PORT_DMA];
   assign sel_we     = sel ? req1_we    : req0_we;
   assign sel_addr   = sel ? req1_addr  : req0_addr;
   assign sel_wdata  = sel ? req1_wdata : req0_wdata;
   assign sel_err    = addr_out_of_range(sel_addr);
   assign rsp_hs     = gnt_port_q ? rsp1_ready : rsp0_ready;
   assign req0_ready = gnt[PORT_CORE];
   assign req1_ready = gnt[PORT_DMA];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_q     <= 1'b1;
         gnt_port_q <= 1'b0;
         rsp_vld_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_rd_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state      <= ST_ACCESS;
                  last_q     <= last_nxt;
                  gnt_port_q <= sel;
                  mem_we_q   <= sel_we & ~sel_err;
                  mem_rd_q   <= ~sel_we & ~sel_err;
               end
            end
            ST_ACCESS: begin
               state     <= ST_RESP;
               mem_we_q  <= 1'b0;
               mem_rd_q  <= 1'b0;
               rsp_vld_q <= 1'b1;
            end
            ST_RESP: begin
               if (rsp_hs) begin
                  state     <= ST_IDLE;
                  rsp_vld_q <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Payload and response data are qualified by state/valid, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= sel_addr;
         wdata_q <= sel_wdata;
         err_q   <= sel_err;
      end
      if (state == ST_ACCESS) begin
         rsp_rdata_q <= mem_rd_q ? mem_read_data : '0;
         rsp_err_q   <= err_q;
      end
   end

   assign mem_access_addr = (state == ST_ACCESS) ? addr_q  : '0;
   assign mem_write_data  = (state == ST_ACCESS) ? wdata_q : '0;
   assign mem_write_en    = mem_we_q;
   assign mem_read        = mem_rd_q;

   assign rsp0_valid = rsp_vld_q & ~gnt_port_q;
   assign rsp1_valid = rsp_vld_q & gnt_port_q;
   assign rsp0_rdata = rsp0_valid ? rsp_rdata_q : '0;
   assign rsp1_rdata = rsp1_valid ? rsp_rdata_q : '0;
   assign rsp0_err   = rsp0_valid & rsp_err_q;
   assign rsp1_err   = rsp1_valid & rsp_err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a behavioural 8x16 memory model.
module tb_data_mem_arbiter;

   typedef struct {
      int          port;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          cyc;
   } txn_t;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready, req0_we;
   logic [15:0] req0_addr, req0_wdata;
   logic        rsp0_valid, rsp0_ready, rsp0_err;
   logic [15:0] rsp0_rdata;
   logic        req1_valid, req1_ready, req1_we;
   logic [15:0] req1_addr, req1_wdata;
   logic        rsp1_valid, rsp1_ready, rsp1_err;
   logic [15:0] rsp1_rdata;
   logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
   logic        mem_write_en, mem_read;

   logic [15:0] mem    [8] = '{default: '0};
   logic [15:0] shadow [8] = '{default: '0};

   txn_t sb[$];
   int   acc_port[$];
   int   acc_cyc[$];
   int   rd_cyc[$];
   int   cyc      = 0;
   int   rise_cyc = 0;
   int   hs_cyc   = 0;
   logic rsp_prev = 1'b0;
   int   n_chk    = 0;
   int   n_pass   = 0;

   data_mem_arbiter dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req0_valid      (req0_valid),
      .req0_ready      (req0_ready),
      .req0_we         (req0_we),
      .req0_addr       (req0_addr),
      .req0_wdata      (req0_wdata),
      .rsp0_valid      (rsp0_valid),
      .rsp0_ready      (rsp0_ready),
      .rsp0_rdata      (rsp0_rdata),
      .rsp0_err        (rsp0_err),
      .req1_valid      (req1_valid),
      .req1_ready      (req1_ready),
      .req1_we         (req1_we),
      .req1_addr       (req1_addr),
      .req1_wdata      (req1_wdata),
      .rsp1_valid      (rsp1_valid),
      .rsp1_ready      (rsp1_ready),
      .rsp1_rdata      (rsp1_rdata),
      .rsp1_err        (rsp1_err),
      .mem_access_addr (mem_access_addr),
      .mem_write_data  (mem_write_data),
      .mem_write_en    (mem_write_en),
      .mem_read        (mem_read),
      .mem_read_data   (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign mem_read_data = mem_read ? mem[mem_access_addr[2:0]] : 16'h0000;
   always @(posedge clk) begin
      if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
   endtask

   task automatic check_rsp(input int p, input logic [15:0] rd, input logic er, input logic other_v);
      txn_t        e;
      logic        oor;
      logic [15:0] exp_rd;
      hs_cyc = cyc;
      if (sb.size() == 0) begin
         chk("rsp_unexpected", 32'd1, 32'd0);
         return;
      end
      e      = sb.pop_front();
      oor    = |e.addr[15:3];
      exp_rd = (e.we || oor) ? 16'h0000 : shadow[e.addr[2:0]];
      chk("rsp_port", p, e.port);
      chk("rsp_rdata", 32'(rd), 32'(exp_rd));
      chk("rsp_err", 32'(er), 32'(oor));
      chk("rsp_other_quiet", 32'(other_v), 32'd0);
      chk("rsp_latency", rise_cyc - e.cyc, 32'd2);
      if (e.we && !oor) shadow[e.addr[2:0]] = e.wdata;
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         rsp_prev = 1'b0;
      end else begin
         chk("ready_excl", 32'(req0_ready & req1_ready), 32'd0);
         chk("we_in_range", 32'(mem_write_en & (|mem_access_addr[15:3])), 32'd0);
         if ((rsp0_valid | rsp1_valid) && !rsp_prev) rise_cyc = cyc;
         rsp_prev = rsp0_valid | rsp1_valid;
         if (rsp0_valid && rsp0_ready) check_rsp(0, rsp0_rdata, rsp0_err, rsp1_valid);
         if (rsp1_valid && rsp1_ready) check_rsp(1, rsp1_rdata, rsp1_err, rsp0_valid);
         if (req0_valid && req0_ready) begin
            sb.push_back('{0, req0_we, req0_addr, req0_wdata, cyc});
            acc_port.push_back(0);
            acc_cyc.push_back(cyc);
         end
         if (req1_valid && req1_ready) begin
            sb.push_back('{1, req1_we, req1_addr, req1_wdata, cyc});
            acc_port.push_back(1);
            acc_cyc.push_back(cyc);
         end
         if (mem_read) rd_cyc.push_back(cyc);
      end
   end

   task automatic do_req(input int p, input logic we, input logic [15:0] addr, input logic [15:0] wd);
      bit done = 1'b0;
      @(posedge clk); #1;
      if (p == 0) begin
         req0_we = we; req0_addr = addr; req0_wdata = wd; req0_valid = 1'b1;
      end else begin
         req1_we = we; req1_addr = addr; req1_wdata = wd; req1_valid = 1'b1;
      end
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) done = 1'b1;
      end
      if (!done) chk("req_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      if (p == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", sb.size(), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ready1", 32'(req1_ready), 32'd0);
      chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      chk("rst_rsp_data", 32'({rsp0_err, rsp1_err, rsp0_rdata | rsp1_rdata}), 32'd0);
      chk("rst_mem_ctl", 32'({mem_write_en, mem_read}), 32'd0);
      chk("rst_mem_addr", 32'(mem_access_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_write_data), 32'd0);
      rst_n = 1'b1;

      // Write then read back on port 0.
      do_req(0, 1'b1, 16'd3, 16'hA5A5);
      @(negedge clk);
      chk("t1_access_we", 32'(mem_write_en), 32'd1);
      chk("t1_access_addr", 32'(mem_access_addr), 32'd3);
      chk("t1_access_wdata", 32'(mem_write_data), 32'hA5A5);
      @(posedge clk); #1;
      chk("t1_commit", 32'(mem[3]), 32'hA5A5);
      wait_drain();
      do_req(0, 1'b0, 16'd3, 16'h0000);
      wait_drain();

      do_req(0, 1'b1, 16'd1, 16'h1111); wait_drain();
      do_req(1, 1'b1, 16'd2, 16'h2222); wait_drain();
      do_req(0, 1'b1, 16'd0, 16'h0BEE); wait_drain();

      // Continuous contention right after reset.
      do_reset();
      acc_port.delete(); acc_cyc.delete();
      @(posedge clk); #1;
      req0_we = 1'b0; req0_addr = 16'd1; req1_we = 1'b0; req1_addr = 16'd2;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 100 && acc_port.size() < 4; i++) begin
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("t2_accepts", acc_port.size(), 32'd4);
      for (int i = 0; i < acc_port.size() && i < 4; i++)
         chk($sformatf("t2_grant%0d", i), acc_port[i], i % 2);
      wait_drain();

      // Out-of-range write on port 1, then read addr 0.
      do_req(1, 1'b1, 16'h0008, 16'hFFFF);
      @(negedge clk);
      chk("t3_no_we", 32'(mem_write_en), 32'd0);
      chk("t3_no_rd", 32'(mem_read), 32'd0);
      wait_drain();
      do_req(0, 1'b0, 16'd0, 16'h0000);
      wait_drain();
      chk("t3_mem0", 32'(mem[0]), 32'h0BEE);

      // Response backpressure on port 0 while port 1 waits.
      rsp0_ready = 1'b0;
      do_req(0, 1'b0, 16'd3, 16'h0000);
      req1_we = 1'b0; req1_addr = 16'd2; req1_valid = 1'b1;
      n0 = acc_port.size();
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", 32'(rsp0_valid), 32'd1);
         chk("t4_hold_rdata", 32'(rsp0_rdata), 32'hA5A5);
         chk("t4_hold_err", 32'(rsp0_err), 32'd0);
         chk("t4_req1_stall", 32'(req1_ready), 32'd0);
      end
      @(posedge clk); #1;
      rsp0_ready = 1'b1;
      for (int i = 0; i < 50 && acc_port.size() <= n0; i++) begin
         @(posedge clk); #1;
      end
      req1_valid = 1'b0;
      chk("t4_req1_accepted", acc_port.size(), n0 + 1);
      if (acc_port.size() > n0) begin
         chk("t4_req1_port", acc_port[n0], 32'd1);
         chk("t4_req1_after_hs", acc_cyc[n0] - hs_cyc, 32'd1);
      end
      wait_drain();

      // Reset during the ACCESS cycle of a write.
      do_req(0, 1'b1, 16'd5, 16'h1234);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_we_drop", 32'(mem_write_en), 32'd0);
      chk("t5_addr_drop", 32'(mem_access_addr), 32'd0);
      chk("t5_wdata_drop", 32'(mem_write_data), 32'd0);
      chk("t5_rsp_drop", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      @(posedge clk); #1;
      chk("t5_mem5", 32'(mem[5]), 32'd0);
      sb.delete();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      end

      // Back-to-back reads with no backpressure.
      rsp0_ready = 1'b1;
      acc_port.delete(); acc_cyc.delete(); rd_cyc.delete();
      do_req(0, 1'b0, 16'd3, 16'h0000);
      do_req(0, 1'b0, 16'd1, 16'h0000);
      do_req(0, 1'b0, 16'd2, 16'h0000);
      wait_drain();
      chk("t6_accepts", acc_cyc.size(), 32'd3);
      chk("t6_reads", rd_cyc.size(), 32'd3);
      if (acc_cyc.size() >= 3) begin
         chk("t6_gap1", acc_cyc[1] - acc_cyc[0], 32'd3);
         chk("t6_gap2", acc_cyc[2] - acc_cyc[0], 32'd6);
         if (rd_cyc.size() >= 3)
            for (int i = 0; i < 3; i++)
               chk($sformatf("t6_read_cyc%0d", i), rd_cyc[i] - acc_cyc[i], 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
